mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit; the write-side producer for the HiLo register pair.
//  Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
//  Drives dinHi/dinLo/hlWrite directly into HiLo (hlWrite[1]=Hi, hlWrite[0]=Lo).
//  busy stalls the EX stage while an operation is in flight.
// PARAMETERS
//  WIDTH  32  operand width; mul/div run WIDTH iteration cycles; dinHi/dinLo are WIDTH bits
// PORTS
//  clk      in   1      clock, all state updates on rising edge
//  rst      in   1      synchronous, active-high reset
//  op       in   3      0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//  opA      in   WIDTH  rs: multiplicand, dividend, or MTHI/MTLO data
//  opB      in   WIDTH  rt: multiplier or divisor
//  busy     out  1      mul/div in progress; new ops are ignored while high
//  dinHi    out  WIDTH  Hi write data (HiLo.dinHi)
//  dinLo    out  WIDTH  Lo write data (HiLo.dinLo)
//  hlWrite  out  2      Hi/Lo write enables (HiLo.hlWrite)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; busy=0, hlWrite=00, dinHi=0, dinLo=0.
//   Reset overrides everything, including an op on the same edge.
//  Outputs are registered. dinHi/dinLo hold their last value while hlWrite=00.
//  FSM states: IDLE, RUN, FIX. busy = (state != IDLE).
//  IDLE:
//   - op in {1..4} at edge E is accepted. Operands are latched, sign flags are captured
//     (signed ops only), operands are converted to magnitudes, counter=0, state goes to RUN.
//   - op = MTHI at edge: dinHi<=opA, hlWrite<=10 for one cycle; state stays IDLE.
//   - op = MTLO at edge: dinLo<=opA, hlWrite<=01 for one cycle; state stays IDLE.
//   - NOP: hlWrite<=00.
//  RUN: one shift-add (mul) or restoring-subtract (div) step per edge.
//   - After WIDTH steps (edges E+1..E+WIDTH), state goes to FIX.
//   - hlWrite=00 throughout; op input is ignored (no queueing).
//  FIX (edge E+WIDTH+1):
//   - Apply sign correction, load dinHi/dinLo, set hlWrite<=11, state goes to IDLE.
//   - The hlWrite=11 pulse lasts exactly one cycle; busy is already 0 during the pulse.
//   - A new op may be accepted on the edge that ends the pulse.
//  Multiply: 2*WIDTH-bit product {Hi,Lo}.
//   - MULT: the product is negated (two's complement, 2*WIDTH bits) when the signs differ.
//  Divide: Lo = quotient, Hi = remainder.
//   - DIV: quotient is negated if the signs differ; remainder takes the sign of the dividend.
//   - DIV overflow (0x80000000 / -1): Lo=0x80000000, Hi=0. This falls out of modulo arithmetic.
//   - Divide by zero (DIV or DIVU): forced to Lo = all ones, Hi = opA as latched (original
//     signed value).
//  rst while in RUN/FIX: the operation is aborted and HiLo is never written.
// STRUCTURE
//  Package mdu_pkg:
//   - op encodings (OP_NOP..OP_MTLO), state enum {IDLE,RUN,FIX}
//   - hlWrite constants HL_NONE=00, HL_LO=01, HL_HI=10, HL_BOTH=11
//  Sub-module mdu_divstep: combinational single restoring-division step.
//   - Inputs: partial remainder, dividend bit, divisor.
//   - Outputs: next remainder, quotient bit.
//  Multiply step, sign fix and FSM stay inline.
// TESTING (WIDTH=32, period 20ns; check hlWrite pulse timing: 1 cycle, WIDTH+1 edges after accept)
//  1. MULTU FFFFFFFF*FFFFFFFF -> Hi=FFFFFFFE Lo=00000001, hlWrite=11 one cycle; busy high 33 cycles.
//  2. MULT FFFFFFFD*00000007 (-3*7) -> Hi=FFFFFFFF Lo=FFFFFFEB.
//  3. DIVU 7/2 -> Hi=1 Lo=3; DIV FFFFFFF9/2 (-7/2) -> Hi=FFFFFFFF Lo=FFFFFFFD.
//  4. DIVU 5/0 -> Hi=5 Lo=FFFFFFFF; DIV 80000000/FFFFFFFF -> Hi=0 Lo=80000000.
//  5. MTHI 11111111 -> next cycle hlWrite=10, dinHi=11111111; MTLO 22222222 -> hlWrite=01,
//     dinLo=22222222, dinHi held.
//  6. Op while busy and reset mid-op:
//     - MULTU issued 5 cycles into a DIVU is ignored; only the DIVU result is written.
//     - rst pulsed mid-RUN -> busy=0, hlWrite stays 00, outputs=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - op encodings presented on mul_div_unit.op
//   - FSM state enum {IDLE, RUN, FIX}
//   - hlWrite enable patterns for the HiLo register pair (bit 1 = Hi, bit 0 = Lo)
package mdu_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  // Encoding 7 is also treated as a NOP.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic [1:0] HL_NONE = 2'b00;
  localparam logic [1:0] HL_LO   = 2'b01;
  localparam logic [1:0] HL_HI   = 2'b10;
  localparam logic [1:0] HL_BOTH = 2'b11;

endpackage

// File: rtl/mdu_divstep.sv
// One combinational restoring-division step.
// Ports:
//   rem_in   in  WIDTH  partial remainder (always < divisor for a nonzero divisor)
//   din_bit  in  1      next dividend bit shifted into the remainder
//   divisor  in  WIDTH  divisor magnitude
//   rem_out  out WIDTH  partial remainder after this step
//   q_bit    out 1      quotient bit produced by this step
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             din_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem_in, din_bit};
    // One extra bit so a borrow shows up as a set MSB.
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    // When the subtraction fits, the result is below the divisor and fits in
    // WIDTH bits; otherwise the shifted value itself is below 2^WIDTH here.
    rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit feeding the HiLo register pair.
// MULT/MULTU/DIV/DIVU take WIDTH iteration cycles plus one fix-up cycle;
// MTHI/MTLO write in a single cycle.
// Ports:
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous active-high reset
//   op       in   3      operation (see mdu_pkg op encodings)
//   opA      in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//   opB      in   WIDTH  multiplier / divisor
//   busy     out  1      operation in flight; new ops ignored while high
//   dinHi    out  WIDTH  Hi write data
//   dinLo    out  WIDTH  Lo write data
//   hlWrite  out  2      Hi/Lo write enables (bit 1 = Hi, bit 0 = Lo)
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic [WIDTH-1:0] dinHi,
  output logic [WIDTH-1:0] dinLo,
  output logic [1:0]       hlWrite
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;     // negate product (mul) or quotient (div)
  logic                 neg_hi_q, neg_hi_d;     // negate remainder (div only)
  logic                 div_zero_q, div_zero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;             // product high half / partial remainder
  logic [WIDTH-1:0]     lo_q, lo_d;             // multiplier+product low / dividend+quotient
  logic [WIDTH-1:0]     b_q, b_d;               // multiplicand / divisor magnitude
  logic [WIDTH-1:0]     a_orig_q, a_orig_d;     // original dividend for divide-by-zero
  logic [WIDTH-1:0]     din_hi_q, din_hi_d;
  logic [WIDTH-1:0]     din_lo_q, din_lo_d;
  logic [1:0]           hl_q, hl_d;

  // Operand preparation at accept time.
  logic                 signed_op;
  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;

  // Datapath step results.
  logic [WIDTH-1:0]     mul_addend;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH-1:0]     div_rem;
  logic                 div_qbit;
  logic [2*WIDTH-1:0]   prod_fix;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    sign_a    = signed_op & opA[WIDTH-1];
    sign_b    = signed_op & opB[WIDTH-1];
    mag_a     = sign_a ? -opA : opA;
    mag_b     = sign_b ? -opB : opB;
  end

  // Shift-add multiply: {hi,lo} holds {partial product, remaining multiplier}.
  // Each step conditionally adds the multiplicand to hi, then shifts the
  // whole pair right by one, keeping the carry-out.
  always_comb begin
    mul_addend = lo_q[0] ? b_q : '0;
    mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
  end

  mdu_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .rem_in  (hi_q),
    .din_bit (lo_q[WIDTH-1]),
    .divisor (b_q),
    .rem_out (div_rem),
    .q_bit   (div_qbit)
  );

  assign prod_fix = neg_lo_q ? -{hi_q, lo_q} : {hi_q, lo_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    b_d        = b_q;
    a_orig_d   = a_orig_q;
    din_hi_d   = din_hi_q;
    din_lo_d   = din_lo_q;
    hl_d       = HL_NONE;

    case (state_q)
      IDLE: begin
        case (op)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            state_d    = RUN;
            cnt_d      = '0;
            is_div_d   = (op == OP_DIV) || (op == OP_DIVU);
            neg_lo_d   = sign_a ^ sign_b;
            neg_hi_d   = sign_a;   // remainder follows the dividend's sign
            div_zero_d = (opB == '0);
            a_orig_d   = opA;
            hi_d       = '0;
            lo_d       = mag_a;
            b_d        = mag_b;
          end
          OP_MTHI: begin
            din_hi_d = opA;
            hl_d     = HL_HI;
          end
          OP_MTLO: begin
            din_lo_d = opA;
            hl_d     = HL_LO;
          end
          default: ;
        endcase
      end

      RUN: begin
        if (is_div_q) begin
          hi_d = div_rem;
          lo_d = {lo_q[WIDTH-2:0], div_qbit};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      FIX: begin
        if (is_div_q) begin
          if (div_zero_q) begin
            din_hi_d = a_orig_q;
            din_lo_d = '1;
          end else begin
            din_hi_d = neg_hi_q ? -hi_q : hi_q;
            din_lo_d = neg_lo_q ? -lo_q : lo_q;
          end
        end else begin
          din_hi_d = prod_fix[2*WIDTH-1:WIDTH];
          din_lo_d = prod_fix[WIDTH-1:0];
        end
        hl_d    = HL_BOTH;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      a_orig_q   <= '0;
      din_hi_q   <= '0;
      din_lo_q   <= '0;
      hl_q       <= HL_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      b_q        <= b_d;
      a_orig_q   <= a_orig_d;
      din_hi_q   <= din_hi_d;
      din_lo_q   <= din_lo_d;
      hl_q       <= hl_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign dinHi   = din_hi_q;
  assign dinLo   = din_lo_q;
  assign hlWrite = hl_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic [31:0] dinHi;
  logic [31:0] dinLo;
  logic [1:0]  hlWrite;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .opA     (opA),
    .opB     (opB),
    .busy    (busy),
    .dinHi   (dinHi),
    .dinLo   (dinLo),
    .hlWrite (hlWrite)
  );

  // Reference: plain arithmetic on the architectural meaning of each op.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (o)
      3'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd3: begin
        if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin
          q = sa / sb;
          r = sa % sb;
          p = 64'(q); lo = p[31:0];
          p = 64'(r); hi = p[31:0];
        end
      end
      3'd4: begin
        if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin hi = a % b; lo = a / b; end
      end
      default: ;
    endcase
  endfunction

  // Issues one op and observes the write pulse. Collects observations only.
  // lat counts negedges after the accept edge's negedge until hlWrite != 0.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat,
                       output int bcnt, output logic [1:0] hw, output logic bz);
    @(negedge clk);
    op = o; opA = a; opB = b;
    @(negedge clk);
    op = 3'd0; opA = $urandom; opB = $urandom;
    lat = 0;
    bcnt = 0;
    while (hlWrite == 2'b00 && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    hi = dinHi; lo = dinLo; hw = hlWrite; bz = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 3'd1; opA = 32'hFFFFFFFD; opB = 32'h7;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (hlWrite !== 2'b00) begin errors++; $display("FAIL reset_hlwrite: got %b expected 00", hlWrite); end
    checks++;
    if (dinHi !== 32'h0 || dinLo !== 32'h0) begin
      errors++; $display("FAIL reset_din: got %h_%h expected 0_0", dinHi, dinLo);
    end
    op = 3'd5; opA = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (hlWrite !== 2'b00 || dinHi !== 32'h0) begin
      errors++; $display("FAIL reset_overrides_op: got hw=%b hi=%h expected hw=00 hi=0", hlWrite, dinHi);
    end
    op = 3'd0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [6] = '{3'd2, 3'd1, 3'd4, 3'd3, 3'd4, 3'd3};
    logic [31:0] t_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFF9, 32'h5, 32'h80000000};
    logic [31:0] t_b  [6] = '{32'hFFFFFFFF, 32'h7, 32'h2, 32'h2, 32'h0, 32'hFFFFFFFF};
    logic [31:0] t_hi [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h5, 32'h0};
    logic [31:0] t_lo [6] = '{32'h00000001, 32'hFFFFFFEB, 32'h3, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] hi, lo;
    int lat, bcnt;
    logic [1:0] hw;
    logic bz;
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i], hi, lo, lat, bcnt, hw, bz);
      $display("directed op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d busy_cycles=%0d", t_op[i], t_a[i], t_b[i], hi, lo, lat, bcnt);
      checks++;
      if (hi !== t_hi[i] || lo !== t_lo[i]) begin
        errors++; $display("FAIL directed_result[%0d]: got %h_%h expected %h_%h", i, hi, lo, t_hi[i], t_lo[i]);
      end
      checks++;
      if (hw !== 2'b11) begin errors++; $display("FAIL directed_hlwrite[%0d]: got %b expected 11", i, hw); end
      checks++;
      if (lat != WIDTH + 1) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, WIDTH + 1); end
      checks++;
      if (bcnt != WIDTH + 1 || bz !== 1'b0) begin
        errors++; $display("FAIL directed_busy[%0d]: got cycles=%0d busy_at_pulse=%b expected %0d and 0", i, bcnt, bz, WIDTH + 1);
      end
      @(negedge clk);
      checks++;
      if (hlWrite !== 2'b00 || dinHi !== t_hi[i] || dinLo !== t_lo[i]) begin
        errors++; $display("FAIL directed_pulse_end[%0d]: got hw=%b %h_%h expected hw=00 %h_%h", i, hlWrite, dinHi, dinLo, t_hi[i], t_lo[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] hi, lo, ehi, elo, a, b;
    logic [2:0] o;
    int lat, bcnt;
    logic [1:0] hw;
    logic bz;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      model(o, a, b, ehi, elo);
      issue(o, a, b, hi, lo, lat, bcnt, hw, bz);
      $display("random op=%0d a=%h b=%h -> hi=%h lo=%h (model %h_%h)", o, a, b, hi, lo, ehi, elo);
      checks++;
      if (hi !== ehi || lo !== elo || hw !== 2'b11 || lat != WIDTH + 1) begin
        errors++; $display("FAIL random[%0d]: got %h_%h hw=%b lat=%0d expected %h_%h hw=11 lat=%0d", i, hi, lo, hw, lat, ehi, elo, WIDTH + 1);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] hold_lo;
    @(negedge clk);
    hold_lo = dinLo;
    op = 3'd5; opA = 32'h11111111;
    @(negedge clk);
    $display("mthi -> hw=%b dinHi=%h", hlWrite, dinHi);
    checks++;
    if (hlWrite !== 2'b10 || dinHi !== 32'h11111111 || dinLo !== hold_lo) begin
      errors++; $display("FAIL mthi: got hw=%b %h_%h expected hw=10 11111111_%h", hlWrite, dinHi, dinLo, hold_lo);
    end
    op = 3'd6; opA = 32'h22222222;
    @(negedge clk);
    $display("mtlo -> hw=%b dinLo=%h", hlWrite, dinLo);
    checks++;
    if (hlWrite !== 2'b01 || dinLo !== 32'h22222222 || dinHi !== 32'h11111111) begin
      errors++; $display("FAIL mtlo: got hw=%b %h_%h expected hw=01 11111111_22222222", hlWrite, dinHi, dinLo);
    end
    op = 3'd7; opA = 32'h33333333;
    @(negedge clk);
    checks++;
    if (hlWrite !== 2'b00 || busy !== 1'b0 || dinHi !== 32'h11111111 || dinLo !== 32'h22222222) begin
      errors++; $display("FAIL nop_hold: got hw=%b busy=%b %h_%h expected hw=00 busy=0 11111111_22222222", hlWrite, busy, dinHi, dinLo);
    end
    op = 3'd0;
  endtask

  task automatic test_busy_ignore();
    int n, extra;
    @(negedge clk);
    op = 3'd4; opA = 32'd100; opB = 32'd7;
    @(negedge clk);
    op = 3'd0;
    repeat (4) @(negedge clk);
    op = 3'd2; opA = 32'hFFFFFFFF; opB = 32'hFFFFFFFF;
    @(negedge clk);
    op = 3'd0;
    n = 0;
    while (hlWrite == 2'b00 && n < 100) begin @(negedge clk); n++; end
    $display("busy_ignore -> hw=%b hi=%h lo=%h", hlWrite, dinHi, dinLo);
    checks++;
    if (hlWrite !== 2'b11 || dinHi !== 32'd2 || dinLo !== 32'd14) begin
      errors++; $display("FAIL busy_ignore_result: got hw=%b %h_%h expected hw=11 00000002_0000000e", hlWrite, dinHi, dinLo);
    end
    extra = 0;
    repeat (WIDTH + 8) begin
      @(negedge clk);
      if (hlWrite != 2'b00 || busy) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL busy_ignore_queued: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid_op();
    int writes;
    logic [31:0] hi, lo, ehi, elo;
    int lat, bcnt;
    logic [1:0] hw;
    logic bz;
    @(negedge clk);
    op = 3'd2; opA = 32'h12345678; opB = 32'h9ABCDEF0;
    @(negedge clk);
    op = 3'd0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset_mid_op -> busy=%b hw=%b hi=%h lo=%h", busy, hlWrite, dinHi, dinLo);
    checks++;
    if (busy !== 1'b0 || hlWrite !== 2'b00 || dinHi !== 32'h0 || dinLo !== 32'h0) begin
      errors++; $display("FAIL reset_mid_op: got busy=%b hw=%b %h_%h expected 0 00 0_0", busy, hlWrite, dinHi, dinLo);
    end
    writes = 0;
    repeat (WIDTH + 8) begin
      @(negedge clk);
      if (hlWrite != 2'b00) writes++;
    end
    checks++;
    if (writes != 0) begin errors++; $display("FAIL reset_mid_op_abort: got %0d writes expected 0", writes); end
    model(3'd3, 32'hFFFFFF9C, 32'd7, ehi, elo);
    issue(3'd3, 32'hFFFFFF9C, 32'd7, hi, lo, lat, bcnt, hw, bz);
    $display("after_reset op=3 -> hi=%h lo=%h", hi, lo);
    checks++;
    if (hi !== ehi || lo !== elo || lat != WIDTH + 1) begin
      errors++; $display("FAIL after_reset_op: got %h_%h lat=%0d expected %h_%h lat=%0d", hi, lo, lat, ehi, elo, WIDTH + 1);
    end
  endtask

  initial begin
    rst = 1'b1; op = 3'd0; opA = '0; opB = '0;
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_random();
    test_busy_ignore();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
